// File: rtl/heichips25_nibble_deser_if.sv
// Bundles the nibble-link receive handshakes, flush, and status outputs of heichips25_nibble_deser.
// master = upstream/consumer side (testbench or core), slave = the deserialiser itself.
interface heichips25_nibble_deser_if #(
  parameter int FIFO_DEPTH = 2
);
  localparam int FILL_W = $clog2(FIFO_DEPTH + 1);

  logic              flush_i;
  logic [3:0]        nib_data_i;
  logic              nib_valid_i;
  logic              nib_ready_o;
  logic [31:0]       word_data_o;
  logic              word_valid_o;
  logic              word_ready_i;
  logic [FILL_W-1:0] fill_o;
  logic              err_o;

  modport master (
    output flush_i, nib_data_i, nib_valid_i, word_ready_i,
    input  nib_ready_o, word_data_o, word_valid_o, fill_o, err_o
  );

  modport slave (
    input  flush_i, nib_data_i, nib_valid_i, word_ready_i,
    output nib_ready_o, word_data_o, word_valid_o, fill_o, err_o
  );
endinterface

// File: rtl/heichips25_nibble_deser.sv
// Nibble-link receiver: packs 8 LSN-first nibbles into 32-bit words and buffers them in a small FIFO.
// Optional partial-word idle timeout is built when NIBBLE_RX_TIMEOUT_EN is defined.
module heichips25_nibble_deser #(
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  heichips25_nibble_deser_if.slave       bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = $clog2(FIFO_DEPTH + 1);

  logic [2:0]        cnt_reg, cnt_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [FILL_W-1:0] fill_reg, fill_next;
  logic [27:0]       lane_word;
  logic [31:0]       push_word;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic              full, empty, nib_acc, push, pop, timeout;

  assign full    = (fill_reg == FILL_W'(FIFO_DEPTH));
  assign empty   = (fill_reg == '0);
  // Only the registered fill level gates the 8th nibble, so a same-cycle pop cannot free a slot.
  assign bus.nib_ready_o  = (cnt_reg != 3'd7) || !full;
  assign nib_acc          = bus.nib_valid_i && bus.nib_ready_o;
  assign push             = nib_acc && (cnt_reg == 3'd7);
  assign pop              = !empty && bus.word_ready_i;
  assign push_word        = {bus.nib_data_i, lane_word};
  assign bus.word_valid_o = !empty;
  assign bus.fill_o       = fill_reg;
  assign bus.word_data_o  = mem_q[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_lane
      logic [3:0] lane_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lane_reg <= '0;
        end else if (bus.flush_i || timeout) begin
          lane_reg <= '0;
        end else if (nib_acc && (cnt_reg == 3'(gi))) begin
          lane_reg <= bus.nib_data_i;
        end
      end
      assign lane_word[4*gi +: 4] = lane_reg;
    end

    // Storage is not cleared by flush; the head is only meaningful while word_valid_o is high.
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [31:0] entry_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (!bus.flush_i && push && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= push_word;
        end
      end
      assign mem_q[gi] = entry_reg;
    end
  endgenerate

`ifdef NIBBLE_RX_TIMEOUT_EN
  logic [15:0] tcnt_reg, tcnt_next;
  logic        err_reg;

  // The timeout fires on the idle cycle that would bring tcnt up to TIMEOUT_CYCLES.
  always_comb begin
    tcnt_next = tcnt_reg;
    timeout   = 1'b0;
    if (nib_acc || (cnt_reg == 3'd0)) begin
      tcnt_next = '0;
    end else if (!bus.nib_valid_i) begin
      if (tcnt_reg == 16'(TIMEOUT_CYCLES - 1)) begin
        timeout   = 1'b1;
        tcnt_next = '0;
      end else begin
        tcnt_next = tcnt_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_reg <= '0;
      err_reg  <= 1'b0;
    end else if (bus.flush_i) begin
      tcnt_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      tcnt_reg <= tcnt_next;
      err_reg  <= timeout;
    end
  end

  assign bus.err_o = err_reg;
`else
  assign timeout   = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  always_comb begin
    cnt_next    = cnt_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    fill_next   = fill_reg;
    if (bus.flush_i) begin
      cnt_next    = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      fill_next   = '0;
    end else begin
      if (nib_acc) begin
        cnt_next = cnt_reg + 3'd1;
      end else if (timeout) begin
        cnt_next = '0;
      end
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fill_next = fill_reg + FILL_W'(1);
        2'b01:   fill_next = fill_reg - FILL_W'(1);
        default: fill_next = fill_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      cnt_reg    <= cnt_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      fill_reg   <= fill_next;
    end
  end
endmodule

// File: tb/tb_heichips25_nibble_deser.sv
// Directed scoreboard bench for heichips25_nibble_deser (FIFO_DEPTH=2, TIMEOUT_CYCLES=10).
// Expectations for the timeout scenario follow whether NIBBLE_RX_TIMEOUT_EN is defined.
module tb_heichips25_nibble_deser;
  localparam int DEPTH = 2;
  localparam int TMO   = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;

  heichips25_nibble_deser_if #(.FIFO_DEPTH(DEPTH)) bus ();

  heichips25_nibble_deser #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          pops;
  int          err_cycles;
  logic [31:0] exp_q [$];
  logic        s_wv, s_nr, s_err, s_acc;
  logic [31:0] s_wd;
  logic [1:0]  s_fill;
  logic [31:0] w0, w1, w2, wa, wb, wx, wc, wf, wp, wq, wz, wr, ww, w6;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: sample on the falling edge, score any pop, then return just after the rising edge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    s_wv   = bus.word_valid_o;
    s_nr   = bus.nib_ready_o;
    s_err  = bus.err_o;
    s_wd   = bus.word_data_o;
    s_fill = bus.fill_o;
    s_acc  = bus.nib_valid_i && bus.nib_ready_o && !bus.flush_i;
    if (s_err) err_cycles++;
    if (!bus.flush_i && s_wv && bus.word_ready_i) begin
      pops++;
      chk("pop_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pop_word", s_wd, e);
      end
      $display("pop word %08h", s_wd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] n, output int stalls);
    logic done;
    done = 1'b0;
    stalls = 0;
    bus.nib_data_i  = n;
    bus.nib_valid_i = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (s_acc) done = 1'b1;
      else stalls++;
    end
    if (!done) chk("nib_accept_bound", 32'd0, 32'd1);
  endtask

  task automatic send_nibs(input logic [31:0] w, input int lo, input int hi, output int stalls);
    int st;
    stalls = 0;
    for (int k = lo; k <= hi; k++) begin
      send_nib(w[4*k +: 4], st);
      stalls += st;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int s2;
    w0 = 32'hDEADBEEF; w1 = 32'h01234567; w2 = 32'hCAFEF00D;
    wa = 32'hA5A50F0F; wb = 32'h13579BDF; wx = 32'h2468ACE0;
    wc = 32'h0F1E2D3C; wf = 32'hFFFFFFFF; wp = 32'h00000DEF;
    wq = 32'h3456789A; wz = 32'h00000000; wr = 32'h11111111;
    ww = 32'h0BADCAFE; w6 = 32'h13572468;
    bus.flush_i = 1'b0; bus.nib_valid_i = 1'b0; bus.nib_data_i = '0; bus.word_ready_i = 1'b0;
    pops = 0; err_cycles = 0;

    // Reset values
    #1 rst = 1'b1;
    #2;
    chk("rst_word_valid", 32'(bus.word_valid_o), 32'd0);
    chk("rst_fill",       32'(bus.fill_o),       32'd0);
    chk("rst_err",        32'(bus.err_o),        32'd0);
    chk("rst_nib_ready",  32'(bus.nib_ready_o),  32'd1);
    chk("rst_word_data",  bus.word_data_o,       32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: single word, consumer always ready
    bus.word_ready_i = 1'b1; pops = 0;
    exp_q.push_back(32'h12345678);
    send_nibs(32'h12345678, 0, 7, st);
    bus.nib_valid_i = 1'b0;
    chk("t1_stalls", st, 0);
    tick(); chk("t1_valid_next", 32'(s_wv), 32'd1);
    tick(); chk("t1_valid_drop", 32'(s_wv), 32'd0);
    chk("t1_pops", pops, 1);

    // 2: fill the FIFO with consumer stalled; only the 3rd word's 8th nibble waits
    bus.word_ready_i = 1'b0; pops = 0;
    exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2);
    send_nibs(w0, 0, 7, st); s2 = st;
    send_nibs(w1, 0, 7, st); s2 += st;
    send_nibs(w2, 0, 6, st); s2 += st;
    chk("t2_no_stall", s2, 0);
    bus.nib_data_i = w2[31:28]; bus.nib_valid_i = 1'b1;
    tick();
    chk("t2_fill_full", 32'(s_fill), 32'd2);
    chk("t2_ready_low", 32'(s_nr), 32'd0);
    bus.word_ready_i = 1'b1;
    tick(); chk("t2_ready_at_pop", 32'(s_nr), 32'd0);
    tick(); chk("t2_ready_after_pop", 32'(s_nr), 32'd1); chk("t2_accepted", 32'(s_acc), 32'd1);
    bus.nib_valid_i = 1'b0;
    repeat (4) tick();
    chk("t2_pops", pops, 3);
    chk("t2_fill_empty", 32'(s_fill), 32'd0);

    // 3: push and pop in the same cycle at fill=1
    bus.word_ready_i = 1'b0; pops = 0;
    exp_q.push_back(wa); exp_q.push_back(wb);
    send_nibs(wa, 0, 7, st);
    send_nibs(wb, 0, 6, st);
    bus.nib_data_i = wb[31:28]; bus.nib_valid_i = 1'b1; bus.word_ready_i = 1'b1;
    tick();
    chk("t3_acc_with_pop", 32'(s_acc), 32'd1);
    bus.nib_valid_i = 1'b0; bus.word_ready_i = 1'b0;
    tick();
    chk("t3_fill", 32'(s_fill), 32'd1);
    chk("t3_head", s_wd, wb);
    chk("t3_pops", pops, 1);
    bus.word_ready_i = 1'b1; tick(); bus.word_ready_i = 1'b0; tick();
    chk("t3_fill_empty", 32'(s_fill), 32'd0);

    // 4: flush with a buffered word, a partial word and a same-cycle nibble
    pops = 0;
    exp_q.push_back(wx);
    send_nibs(wx, 0, 7, st);
    send_nibs(wf, 0, 3, st);
    bus.nib_data_i = 4'hF; bus.nib_valid_i = 1'b1; bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0; bus.nib_valid_i = 1'b0;
    exp_q.delete();
    tick();
    chk("t4_fill", 32'(s_fill), 32'd0);
    chk("t4_valid", 32'(s_wv), 32'd0);
    bus.word_ready_i = 1'b1;
    exp_q.push_back(wc);
    send_nibs(wc, 0, 7, st);
    bus.nib_valid_i = 1'b0;
    tick(); tick();
    chk("t4_pops", pops, 1);

    // 5: partial word followed by 10 idle cycles
    pops = 0; err_cycles = 0;
    send_nibs(wp, 0, 2, st);
    bus.nib_valid_i = 1'b0;
    repeat (TMO) tick();
`ifdef NIBBLE_RX_TIMEOUT_EN
    exp_q.push_back(32'h3456789A);
    send_nibs(wq, 0, 7, st);
    bus.nib_valid_i = 1'b0;
    tick(); tick();
    chk("t5_err_cycles", err_cycles, 1);
    chk("t5_pops", pops, 1);
`else
    exp_q.push_back(32'h6789ADEF);
    exp_q.push_back(32'h00000345);
    send_nibs(wq, 0, 7, st);
    send_nibs(wz, 0, 4, st);
    bus.nib_valid_i = 1'b0;
    tick(); tick();
    chk("t5_err_cycles", err_cycles, 0);
    chk("t5_pops", pops, 2);
`endif

    // 6: asynchronous reset mid-word with one word buffered
    bus.word_ready_i = 1'b0; pops = 0;
    exp_q.push_back(ww);
    send_nibs(ww, 0, 7, st);
    send_nibs(wr, 0, 2, st);
    bus.nib_valid_i = 1'b0;
    tick();
    chk("t6_fill_before", 32'(s_fill), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_word_valid", 32'(bus.word_valid_o), 32'd0);
    chk("t6_fill",       32'(bus.fill_o),       32'd0);
    chk("t6_nib_ready",  32'(bus.nib_ready_o),  32'd1);
    chk("t6_word_data",  bus.word_data_o,       32'd0);
    chk("t6_err",        32'(bus.err_o),        32'd0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    bus.word_ready_i = 1'b1;
    exp_q.push_back(w6);
    send_nibs(w6, 0, 7, st);
    bus.nib_valid_i = 1'b0;
    repeat (3) tick();
    chk("t6_pops", pops, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
